ofm_write_buffer: RTL

- Ping-pong staging buffer directly upstream of the OFM write address controller.
- Captures per-filter output vectors drained from the systolic array.
- Applies shift, optional ReLU and saturation to each lane.
- Replays each captured group as a channel burst, timed so the vector for channel k lines up with the address controller's ofm_addr for channel k.
- Drives that controller's write pulse and supplies the OFM RAM write data and lane enables.

---
 rtl/ofm_write_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ofm_write_buffer.sv
// Ping-pong OFM staging buffer: converts drained accumulator vectors and replays
// each captured group as a channel burst aligned to the OFM write address controller.
module ofm_write_buffer #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]  in_data,
  output logic                                in_ready,
  input  logic [4:0]                          read_wgt_size,
  input  logic [4:0]                          write_ofm_size,
  input  logic [3:0]                          shift,
  input  logic                                relu_en,
  output logic                                write,
  output logic                                ofm_valid,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ofm_data,
  output logic [SYSTOLIC_SIZE-1:0]            ofm_lane_en,
  output logic                                busy
);

  localparam int unsigned IDX_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int unsigned VEC_W = SYSTOLIC_SIZE * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       drain_k, k_d;
  logic [IDX_W-1:0]       fill_idx, fill_idx_d;
  logic                   fill_bank, fill_bank_d;
  logic                   drain_bank, drain_bank_d;
  logic [1:0]             full, full_d;
  logic                   accept;
  logic [IDX_W-1:0]       n_last;
  logic [VEC_W-1:0]       conv_vec;
  logic signed [ACC_WIDTH-1:0] lane_y;
  logic                   write_d, valid_d, ready_d, busy_d;
  logic [VEC_W-1:0]       data_d;
  logic [SYSTOLIC_SIZE-1:0] lane_en_d;

  logic [VEC_W-1:0] mem [2][SYSTOLIC_SIZE];

  // Group size N-1; zero means one vector, oversize clamps to the bank depth
  always_comb begin
    if (read_wgt_size == 5'd0)
      n_last = '0;
    else if (32'(read_wgt_size) >= SYSTOLIC_SIZE)
      n_last = IDX_W'(SYSTOLIC_SIZE - 1);
    else
      n_last = IDX_W'(read_wgt_size - 5'd1);
  end

  // Per-lane shift, optional ReLU, saturation to DATA_WIDTH
  always_comb begin
    conv_vec = '0;
    lane_y   = '0;
    for (int i = 0; i < int'(SYSTOLIC_SIZE); i++) begin
      lane_y = $signed(in_data[i*ACC_WIDTH +: ACC_WIDTH]) >>> shift;
      if (relu_en && lane_y[ACC_WIDTH-1]) lane_y = '0;
      if (lane_y > SAT_MAX)      lane_y = SAT_MAX;
      else if (lane_y < SAT_MIN) lane_y = SAT_MIN;
      conv_vec[i*DATA_WIDTH +: DATA_WIDTH] = lane_y[DATA_WIDTH-1:0];
    end
  end

  // Next-state for fill side, drain FSM and registered outputs
  always_comb begin
    state_d      = state_q;
    k_d          = drain_k;
    fill_idx_d   = fill_idx;
    fill_bank_d  = fill_bank;
    drain_bank_d = drain_bank;
    full_d       = full;
    accept       = 1'b0;
    write_d      = 1'b0;
    valid_d      = 1'b0;
    data_d       = '0;
    lane_en_d    = '0;

    if (start) begin
      state_d      = S_IDLE;
      k_d          = '0;
      fill_idx_d   = '0;
      fill_bank_d  = 1'b0;
      drain_bank_d = 1'b0;
      full_d       = '0;
    end else begin
      accept = in_valid & in_ready;
      if (accept) begin
        if (fill_idx >= n_last) begin
          full_d[fill_bank] = 1'b1;
          fill_idx_d        = '0;
          fill_bank_d       = ~fill_bank;
        end else begin
          fill_idx_d = fill_idx + IDX_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (full[drain_bank]) begin
            state_d = S_BURST;
            k_d     = '0;
          end
        end
        S_BURST: begin
          if (drain_k >= n_last) begin
            full_d[drain_bank] = 1'b0;
            drain_bank_d       = ~drain_bank;
            state_d            = S_GAP;
          end else begin
            k_d = drain_k + IDX_W'(1);
          end
        end
        S_GAP:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs describe the cycle the FSM is about to enter
    if (state_d == S_BURST) begin
      valid_d = 1'b1;
      write_d = (k_d == '0);
      data_d  = mem[drain_bank][k_d];
      for (int i = 0; i < int'(SYSTOLIC_SIZE); i++)
        lane_en_d[i] = (i < int'(write_ofm_size));
    end

    ready_d = ~full_d[fill_bank_d];
    busy_d  = (|full_d) | (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_k     <= '0;
      fill_idx    <= '0;
      fill_bank   <= 1'b0;
      drain_bank  <= 1'b0;
      full        <= '0;
      write       <= 1'b0;
      ofm_valid   <= 1'b0;
      ofm_data    <= '0;
      ofm_lane_en <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_k     <= k_d;
      fill_idx    <= fill_idx_d;
      fill_bank   <= fill_bank_d;
      drain_bank  <= drain_bank_d;
      full        <= full_d;
      write       <= write_d;
      ofm_valid   <= valid_d;
      ofm_data    <= data_d;
      ofm_lane_en <= lane_en_d;
      in_ready    <= ready_d;
      busy        <= busy_d;
    end
  end

  // Bank storage; never read before the owning bank is marked full
  always_ff @(posedge clk) begin
    if (accept) mem[fill_bank][fill_idx] <= conv_vec;
  end

endmodule
